// File: rtl/id_ctrl_pkg.sv
// Shared opcode, ALU-op and control-bundle definitions for the ID decode stage.
package id_ctrl_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  localparam logic [2:0] ALU_NONE  = 3'b000;
  localparam logic [2:0] ALU_RTYPE = 3'b010;
  localparam logic [2:0] ALU_ADD   = 3'b100;
  localparam logic [2:0] ALU_SUB   = 3'b101;
  localparam logic [2:0] ALU_SLT   = 3'b111;

  localparam logic [1:0] RD_RT  = 2'b00;
  localparam logic [1:0] RD_RD  = 2'b01;
  localparam logic [1:0] RD_R31 = 2'b10;

  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MEM = 2'b01;
  localparam logic [1:0] M2R_PC4 = 2'b10;

  typedef struct packed {
    logic       reg_write;
    logic [2:0] alu_op;
    logic       alu_src;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       branch;
    logic       jump;
    logic       mem_read;
    logic       mem_write;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  typedef enum logic {ST_RUN, ST_STALL} state_t;

endpackage

// File: rtl/id_ctrl_decode.sv
// Combinational opcode decoder: produces the control bundle, the illegal flag
// and whether the instruction reads rt as a source operand.
module id_ctrl_decode
  import id_ctrl_pkg::*;
#(
  parameter int OP_W    = 6,
  parameter bit EN_JUMP = 1'b1
) (
  input  logic [OP_W-1:0] i_opcode,
  output ctrl_t           o_ctrl,
  output logic            o_illegal,
  output logic            o_uses_rt
);

  logic [5:0] w_op;
  logic       w_hi_zero;

  assign w_op = i_opcode[5:0];

  generate
    if (OP_W > 6) begin : g_hi
      assign w_hi_zero = ~|i_opcode[OP_W-1:6];
    end else begin : g_no_hi
      assign w_hi_zero = 1'b1;
    end
  endgenerate

  always_comb begin
    o_ctrl    = CTRL_NOP;
    o_illegal = 1'b0;
    o_uses_rt = 1'b0;
    if (!w_hi_zero) begin
      o_illegal = 1'b1;
    end else if (w_op == OP_R) begin
      o_ctrl.reg_write = 1'b1;
      o_ctrl.reg_dst   = RD_RD;
      o_ctrl.alu_op    = ALU_RTYPE;
      o_uses_rt        = 1'b1;
    end else if (w_op[5:3] == 3'b001) begin
      o_ctrl.reg_write = 1'b1;
      o_ctrl.alu_src   = 1'b1;
      o_ctrl.alu_op    = (w_op == OP_SLTI) ? ALU_SLT : ALU_ADD;
    end else if (w_op == OP_LW) begin
      o_ctrl.reg_write  = 1'b1;
      o_ctrl.alu_src    = 1'b1;
      o_ctrl.alu_op     = ALU_ADD;
      o_ctrl.mem_read   = 1'b1;
      o_ctrl.mem_to_reg = M2R_MEM;
    end else if (w_op == OP_SW) begin
      o_ctrl.alu_src   = 1'b1;
      o_ctrl.alu_op    = ALU_ADD;
      o_ctrl.mem_write = 1'b1;
      o_uses_rt        = 1'b1;
    end else if (w_op == OP_BEQ) begin
      o_ctrl.branch = 1'b1;
      o_ctrl.alu_op = ALU_SUB;
      o_uses_rt     = 1'b1;
    end else if (EN_JUMP && (w_op == OP_J)) begin
      o_ctrl.jump = 1'b1;
    end else if (EN_JUMP && (w_op == OP_JAL)) begin
      o_ctrl.jump       = 1'b1;
      o_ctrl.reg_write  = 1'b1;
      o_ctrl.reg_dst    = RD_R31;
      o_ctrl.mem_to_reg = M2R_PC4;
    end else begin
      o_illegal = 1'b1;
    end
  end

endmodule

// File: rtl/id_decode_stage.sv
// Registered ID stage: decodes IF/ID, inserts one bubble per lw-use hazard,
// and drives ID/EX with valid/ready handshake, flush and a bubble counter.
//   state    | meaning
//   ST_RUN   | normal issue; lw-use hazard checked against held instruction
//   ST_STALL | bubble is held for one cycle; dependent instruction issues next
module id_decode_stage
  import id_ctrl_pkg::*;
#(
  parameter int OP_W    = 6,
  parameter int RA_W    = 5,
  parameter int ALUOP_W = 3,
  parameter bit EN_JUMP = 1'b1,
  parameter int CNT_W   = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [31:0]        instr_i,
  input  logic               flush_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic               reg_write_o,
  output logic [ALUOP_W-1:0] alu_op_o,
  output logic               alu_src_o,
  output logic [1:0]         reg_dst_o,
  output logic [1:0]         mem_to_reg_o,
  output logic               branch_o,
  output logic               jump_o,
  output logic               mem_read_o,
  output logic               mem_write_o,
  output logic [RA_W-1:0]    rs_o,
  output logic [RA_W-1:0]    rt_o,
  output logic [RA_W-1:0]    rd_o,
  output logic               illegal_o,
  output logic [CNT_W-1:0]   bubble_cnt_o
);

  state_t           r_state;
  logic             r_valid;
  ctrl_t            r_ctrl;
  logic             r_illegal;
  logic [RA_W-1:0]  r_rs, r_rt, r_rd;
  logic [CNT_W-1:0] r_cnt;

  state_t           w_state_nxt;
  logic             w_valid_nxt;
  ctrl_t            w_ctrl_nxt;
  logic             w_illegal_nxt;
  logic [RA_W-1:0]  w_rs_nxt, w_rt_nxt, w_rd_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;

  logic [OP_W-1:0]  w_opcode;
  ctrl_t            w_dec_ctrl;
  logic             w_dec_illegal;
  logic             w_uses_rt;
  logic [RA_W-1:0]  w_rs_in, w_rt_in, w_rd_in;
  logic             w_adv;
  logic             w_haz;
  logic             w_in_ready;
  logic             w_unused;

  assign w_opcode = OP_W'(instr_i[31:26]);
  assign w_rs_in  = RA_W'(instr_i[25:21]);
  assign w_rt_in  = RA_W'(instr_i[20:16]);
  assign w_rd_in  = RA_W'(instr_i[15:11]);
  assign w_unused = ^instr_i[10:0];

  id_ctrl_decode #(
    .OP_W    (OP_W),
    .EN_JUMP (EN_JUMP)
  ) u_dec (
    .i_opcode  (w_opcode),
    .o_ctrl    (w_dec_ctrl),
    .o_illegal (w_dec_illegal),
    .o_uses_rt (w_uses_rt)
  );

  assign w_adv = ~r_valid | out_ready_i;
  // Only a held lw with a nonzero destination can create a load-use hazard.
  assign w_haz = r_valid & r_ctrl.mem_read & (r_rt != '0) & in_valid_i &
                 ((w_rs_in == r_rt) | (w_uses_rt & (w_rt_in == r_rt)));

  always_comb begin
    w_state_nxt   = r_state;
    w_valid_nxt   = r_valid;
    w_ctrl_nxt    = r_ctrl;
    w_illegal_nxt = r_illegal;
    w_rs_nxt      = r_rs;
    w_rt_nxt      = r_rt;
    w_rd_nxt      = r_rd;
    w_cnt_nxt     = r_cnt;
    w_in_ready    = 1'b0;

    if (flush_i) begin
      w_in_ready    = 1'b1;
      w_state_nxt   = ST_RUN;
      w_valid_nxt   = 1'b0;
      w_ctrl_nxt    = CTRL_NOP;
      w_illegal_nxt = 1'b0;
      w_rs_nxt      = '0;
      w_rt_nxt      = '0;
      w_rd_nxt      = '0;
    end else begin
      case (r_state)
        ST_RUN:   w_in_ready = w_adv & ~w_haz;
        ST_STALL: w_in_ready = w_adv;
        default:  w_in_ready = 1'b0;
      endcase

      if (w_adv && (r_state == ST_RUN) && w_haz) begin
        w_state_nxt   = ST_STALL;
        w_valid_nxt   = 1'b0;
        w_ctrl_nxt    = CTRL_NOP;
        w_illegal_nxt = 1'b0;
        w_rs_nxt      = '0;
        w_rt_nxt      = '0;
        w_rd_nxt      = '0;
        if (r_cnt != {CNT_W{1'b1}}) w_cnt_nxt = r_cnt + 1'b1;
      end else if (w_adv) begin
        w_state_nxt = ST_RUN;
        if (in_valid_i) begin
          w_valid_nxt   = 1'b1;
          w_ctrl_nxt    = w_dec_ctrl;
          w_illegal_nxt = w_dec_illegal;
          w_rs_nxt      = w_rs_in;
          w_rt_nxt      = w_rt_in;
          w_rd_nxt      = w_rd_in;
        end else begin
          w_valid_nxt   = 1'b0;
          w_ctrl_nxt    = CTRL_NOP;
          w_illegal_nxt = 1'b0;
          w_rs_nxt      = '0;
          w_rt_nxt      = '0;
          w_rd_nxt      = '0;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= ST_RUN;
      r_valid   <= 1'b0;
      r_ctrl    <= CTRL_NOP;
      r_illegal <= 1'b0;
      r_rs      <= '0;
      r_rt      <= '0;
      r_rd      <= '0;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_valid   <= w_valid_nxt;
      r_ctrl    <= w_ctrl_nxt;
      r_illegal <= w_illegal_nxt;
      r_rs      <= w_rs_nxt;
      r_rt      <= w_rt_nxt;
      r_rd      <= w_rd_nxt;
      r_cnt     <= w_cnt_nxt;
    end
  end

  assign in_ready_o   = w_in_ready;
  assign out_valid_o  = r_valid;
  assign reg_write_o  = r_ctrl.reg_write;
  assign alu_op_o     = ALUOP_W'(r_ctrl.alu_op);
  assign alu_src_o    = r_ctrl.alu_src;
  assign reg_dst_o    = r_ctrl.reg_dst;
  assign mem_to_reg_o = r_ctrl.mem_to_reg;
  assign branch_o     = r_ctrl.branch;
  assign jump_o       = r_ctrl.jump;
  assign mem_read_o   = r_ctrl.mem_read;
  assign mem_write_o  = r_ctrl.mem_write;
  assign rs_o         = r_rs;
  assign rt_o         = r_rt;
  assign rd_o         = r_rd;
  assign illegal_o    = r_illegal;
  assign bubble_cnt_o = r_cnt;

endmodule

// File: tb/tb_id_decode_stage.sv
// Directed bench for id_decode_stage: a jump-enabled instance and a
// jump-disabled instance with a 2-bit bubble counter share all stimulus.
module tb_id_decode_stage;

  logic        clk = 1'b0;
  logic        rst, in_valid, flush, out_ready;
  logic [31:0] instr;

  logic        in_ready, out_valid, reg_write, alu_src, branch, jump, mem_read, mem_write, illegal;
  logic [2:0]  alu_op;
  logic [1:0]  reg_dst, mem_to_reg;
  logic [4:0]  rs, rt, rd;
  logic [15:0] bubble_cnt;

  logic        nj_in_ready, nj_out_valid, nj_reg_write, nj_alu_src, nj_branch, nj_jump;
  logic        nj_mem_read, nj_mem_write, nj_illegal;
  logic [2:0]  nj_alu_op;
  logic [1:0]  nj_reg_dst, nj_mem_to_reg;
  logic [4:0]  nj_rs, nj_rt, nj_rd;
  logic [1:0]  nj_bubble_cnt;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  id_decode_stage #(.OP_W(6), .RA_W(5), .ALUOP_W(3), .EN_JUMP(1'b1), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready), .instr_i(instr),
    .flush_i(flush), .out_valid_o(out_valid), .out_ready_i(out_ready), .reg_write_o(reg_write),
    .alu_op_o(alu_op), .alu_src_o(alu_src), .reg_dst_o(reg_dst), .mem_to_reg_o(mem_to_reg),
    .branch_o(branch), .jump_o(jump), .mem_read_o(mem_read), .mem_write_o(mem_write),
    .rs_o(rs), .rt_o(rt), .rd_o(rd), .illegal_o(illegal), .bubble_cnt_o(bubble_cnt)
  );

  id_decode_stage #(.OP_W(6), .RA_W(5), .ALUOP_W(3), .EN_JUMP(1'b0), .CNT_W(2)) dut_nj (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(nj_in_ready), .instr_i(instr),
    .flush_i(flush), .out_valid_o(nj_out_valid), .out_ready_i(out_ready), .reg_write_o(nj_reg_write),
    .alu_op_o(nj_alu_op), .alu_src_o(nj_alu_src), .reg_dst_o(nj_reg_dst), .mem_to_reg_o(nj_mem_to_reg),
    .branch_o(nj_branch), .jump_o(nj_jump), .mem_read_o(nj_mem_read), .mem_write_o(nj_mem_write),
    .rs_o(nj_rs), .rt_o(nj_rt), .rd_o(nj_rd), .illegal_o(nj_illegal), .bubble_cnt_o(nj_bubble_cnt)
  );

  function automatic logic [31:0] r_type(input logic [4:0] s, input logic [4:0] t, input logic [4:0] d);
    return {6'b000000, s, t, d, 5'd0, 6'h20};
  endfunction

  function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] s, input logic [4:0] t);
    return {op, s, t, 16'h0004};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1; instr = r_type(5'd1, 5'd2, 5'd3);
    tick(); tick();
    n_checks++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%0h exp=0", out_valid); end
    n_checks++; if (reg_write !== 1'b0 || alu_op !== 3'b000 || reg_dst !== 2'b00 || rd !== 5'd0) begin
      n_err++; $display("FAIL reset_ctrl got rw=%0h aluop=%0h rdst=%0h rd=%0h exp all 0", reg_write, alu_op, reg_dst, rd); end
    n_checks++; if (illegal !== 1'b0 || bubble_cnt !== 16'd0) begin
      n_err++; $display("FAIL reset_ill_cnt got ill=%0h cnt=%0h exp 0/0", illegal, bubble_cnt); end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    tick();
  endtask

  task automatic test_r_then_i();
    in_valid = 1'b1; instr = r_type(5'd1, 5'd2, 5'd3);
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL r_in_ready got=%0h exp=1", in_ready); end
    tick();
    n_checks++; if (out_valid !== 1'b1 || reg_dst !== 2'b01 || alu_op !== 3'b010 || reg_write !== 1'b1 || alu_src !== 1'b0) begin
      n_err++; $display("FAIL r_bundle got v=%0h rdst=%0h aluop=%0h rw=%0h src=%0h exp 1/1/2/1/0", out_valid, reg_dst, alu_op, reg_write, alu_src); end
    n_checks++; if (rs !== 5'd1 || rt !== 5'd2 || rd !== 5'd3) begin
      n_err++; $display("FAIL r_fields got rs=%0d rt=%0d rd=%0d exp 1/2/3", rs, rt, rd); end
    instr = i_type(6'b001000, 5'd1, 5'd4);
    tick();
    n_checks++; if (out_valid !== 1'b1 || alu_src !== 1'b1 || alu_op !== 3'b100 || reg_write !== 1'b1 || reg_dst !== 2'b00) begin
      n_err++; $display("FAIL addi_bundle got v=%0h src=%0h aluop=%0h rw=%0h rdst=%0h exp 1/1/4/1/0", out_valid, alu_src, alu_op, reg_write, reg_dst); end
    in_valid = 1'b0;
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL drain_valid got=%0h exp=0", out_valid); end
  endtask

  task automatic test_lw_use();
    in_valid = 1'b1; instr = i_type(6'b100011, 5'd1, 5'd8);
    tick();
    n_checks++; if (mem_read !== 1'b1 || mem_to_reg !== 2'b01 || alu_src !== 1'b1 || rt !== 5'd8) begin
      n_err++; $display("FAIL lw_bundle got mr=%0h m2r=%0h src=%0h rt=%0d exp 1/1/1/8", mem_read, mem_to_reg, alu_src, rt); end
    instr = r_type(5'd8, 5'd3, 5'd9);
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL haz_in_ready got=%0h exp=0", in_ready); end
    tick();
    n_checks++; if (out_valid !== 1'b0 || reg_write !== 1'b0 || bubble_cnt !== 16'd1) begin
      n_err++; $display("FAIL bubble got v=%0h rw=%0h cnt=%0d exp 0/0/1", out_valid, reg_write, bubble_cnt); end
    n_checks++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL stall_in_ready got=%0h exp=1", in_ready); end
    tick();
    n_checks++; if (out_valid !== 1'b1 || rd !== 5'd9 || reg_dst !== 2'b01 || bubble_cnt !== 16'd1) begin
      n_err++; $display("FAIL add_after_bubble got v=%0h rd=%0d rdst=%0h cnt=%0d exp 1/9/1/1", out_valid, rd, reg_dst, bubble_cnt); end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_hazard_variants();
    in_valid = 1'b1; instr = i_type(6'b100011, 5'd1, 5'd0);
    tick();
    instr = r_type(5'd0, 5'd0, 5'd9);
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL lw_r0_in_ready got=%0h exp=1", in_ready); end
    tick();
    n_checks++; if (out_valid !== 1'b1 || rd !== 5'd9 || bubble_cnt !== 16'd1) begin
      n_err++; $display("FAIL lw_r0_nobubble got v=%0h rd=%0d cnt=%0d exp 1/9/1", out_valid, rd, bubble_cnt); end
    instr = i_type(6'b100011, 5'd1, 5'd8);
    tick();
    instr = i_type(6'b001000, 5'd7, 5'd8);
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL addi_rt_dest_in_ready got=%0h exp=1", in_ready); end
    tick();
    instr = i_type(6'b100011, 5'd1, 5'd8);
    tick();
    instr = i_type(6'b101011, 5'd2, 5'd8);
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL sw_haz_in_ready got=%0h exp=0", in_ready); end
    tick();
    n_checks++; if (out_valid !== 1'b0 || bubble_cnt !== 16'd2) begin
      n_err++; $display("FAIL sw_bubble got v=%0h cnt=%0d exp 0/2", out_valid, bubble_cnt); end
    tick();
    n_checks++; if (out_valid !== 1'b1 || mem_write !== 1'b1 || alu_src !== 1'b1 || reg_write !== 1'b0) begin
      n_err++; $display("FAIL sw_bundle got v=%0h mw=%0h src=%0h rw=%0h exp 1/1/1/0", out_valid, mem_write, alu_src, reg_write); end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_jal();
    in_valid = 1'b1; instr = {6'b000011, 26'h0000010};
    tick();
    n_checks++; if (reg_dst !== 2'b10 || mem_to_reg !== 2'b10 || jump !== 1'b1 || reg_write !== 1'b1 || illegal !== 1'b0) begin
      n_err++; $display("FAIL jal_bundle got rdst=%0h m2r=%0h j=%0h rw=%0h ill=%0h exp 2/2/1/1/0", reg_dst, mem_to_reg, jump, reg_write, illegal); end
    n_checks++; if (nj_out_valid !== 1'b1 || nj_illegal !== 1'b1 || nj_reg_write !== 1'b0 || nj_jump !== 1'b0 || nj_reg_dst !== 2'b00 || nj_mem_to_reg !== 2'b00) begin
      n_err++; $display("FAIL jal_nojump got v=%0h ill=%0h rw=%0h j=%0h rdst=%0h m2r=%0h exp 1/1/0/0/0/0", nj_out_valid, nj_illegal, nj_reg_write, nj_jump, nj_reg_dst, nj_mem_to_reg); end
    instr = {6'b000010, 26'h0000020};
    tick();
    n_checks++; if (jump !== 1'b1 || reg_write !== 1'b0 || nj_illegal !== 1'b1) begin
      n_err++; $display("FAIL j_bundle got j=%0h rw=%0h nj_ill=%0h exp 1/0/1", jump, reg_write, nj_illegal); end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure_flush();
    in_valid = 1'b1; out_ready = 1'b1; instr = i_type(6'b000100, 5'd1, 5'd2);
    tick();
    n_checks++; if (branch !== 1'b1 || alu_op !== 3'b101) begin
      n_err++; $display("FAIL beq_bundle got br=%0h aluop=%0h exp 1/5", branch, alu_op); end
    out_ready = 1'b0; instr = r_type(5'd4, 5'd5, 5'd6);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL stall_in_ready[%0d] got=%0h exp=0", i, in_ready); end
      tick();
      n_checks++; if (out_valid !== 1'b1 || branch !== 1'b1 || rs !== 5'd1 || rt !== 5'd2) begin
        n_err++; $display("FAIL stall_hold[%0d] got v=%0h br=%0h rs=%0d rt=%0d exp 1/1/1/2", i, out_valid, branch, rs, rt); end
    end
    flush = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL flush_in_ready got=%0h exp=1", in_ready); end
    tick();
    n_checks++; if (out_valid !== 1'b0 || branch !== 1'b0) begin
      n_err++; $display("FAIL flush_out got v=%0h br=%0h exp 0/0", out_valid, branch); end
    flush = 1'b0; out_ready = 1'b1;
    instr = i_type(6'b100011, 5'd1, 5'd8);
    tick();
    instr = r_type(5'd8, 5'd3, 5'd9); flush = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL flush_haz_in_ready got=%0h exp=1", in_ready); end
    tick();
    n_checks++; if (out_valid !== 1'b0 || bubble_cnt !== 16'd2) begin
      n_err++; $display("FAIL flush_beats_haz got v=%0h cnt=%0d exp 0/2", out_valid, bubble_cnt); end
    flush = 1'b0; in_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_in_stall();
    in_valid = 1'b1; instr = i_type(6'b100011, 5'd1, 5'd8);
    tick();
    instr = r_type(5'd8, 5'd3, 5'd9);
    tick();
    n_checks++; if (out_valid !== 1'b0 || bubble_cnt !== 16'd3) begin
      n_err++; $display("FAIL pre_rst_bubble got v=%0h cnt=%0d exp 0/3", out_valid, bubble_cnt); end
    rst = 1'b1;
    tick();
    n_checks++; if (out_valid !== 1'b0 || reg_write !== 1'b0 || rd !== 5'd0 || bubble_cnt !== 16'd0 || nj_bubble_cnt !== 2'd0) begin
      n_err++; $display("FAIL rst_in_stall got v=%0h rw=%0h rd=%0d cnt=%0d njcnt=%0d exp all 0", out_valid, reg_write, rd, bubble_cnt, nj_bubble_cnt); end
    rst = 1'b0; instr = {6'b111111, 26'h0};
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL post_rst_in_ready got=%0h exp=1", in_ready); end
    tick();
    n_checks++; if (out_valid !== 1'b1 || illegal !== 1'b1 || reg_write !== 1'b0 || alu_op !== 3'b000) begin
      n_err++; $display("FAIL illegal_op got v=%0h ill=%0h rw=%0h aluop=%0h exp 1/1/0/0", out_valid, illegal, reg_write, alu_op); end
    in_valid = 1'b0;
    tick();
    n_checks++; if (illegal !== 1'b0 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL illegal_clear got ill=%0h v=%0h exp 0/0", illegal, out_valid); end
  endtask

  task automatic test_saturation();
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      instr = i_type(6'b100011, 5'd1, 5'd8);
      tick();
      instr = r_type(5'd2, 5'd8, 5'd9);
      tick();
      tick();
    end
    n_checks++; if (bubble_cnt !== 16'd4) begin n_err++; $display("FAIL bubble_count4 got=%0d exp=4", bubble_cnt); end
    n_checks++; if (nj_bubble_cnt !== 2'd3) begin n_err++; $display("FAIL bubble_saturate got=%0d exp=3", nj_bubble_cnt); end
    in_valid = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1; instr = '0;
    test_reset();
    test_r_then_i();
    test_lw_use();
    test_hazard_variants();
    test_jal();
    test_backpressure_flush();
    test_reset_in_stall();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
